// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: launches FFT frames from the mic sample window.
// Ports: clk, reset (sync, active-low), new_t/enable/fft_done in;
//   snap, fft_start, fft_active, window_ready, frame_cnt, drop_cnt,
//   fft_err out. Optional watchdog: define FFT_WATCHDOG_EN.

module fft_frame_scheduler #(
  parameter int WIN_LEN = 32,
  parameter int HOP     = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_t,
  input  logic        enable,
  input  logic        fft_done,
  output logic        snap,
  output logic        fft_start,
  output logic        fft_active,
  output logic        window_ready,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic        fft_err
);

  localparam int FW = $clog2(WIN_LEN + 1);

  localparam logic [FW-1:0] FILL_MAX  = FW'(WIN_LEN);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIN_LEN - 1);
  localparam logic [FW-1:0] HOP_LAST  = FW'(HOP - 1);
  localparam logic [FW-1:0] ONE       = FW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_START,
    S_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] hop_q, hop_d;
  logic [15:0]   frame_q, frame_d;
  logic [7:0]    drop_q, drop_d;
  logic          due;
  logic          launch;
  logic          drop_inc;

  // Sample accounting: initial fill, then one frame every HOP samples.
  always_comb begin
    fill_d = fill_q;
    hop_d  = hop_q;
    due    = 1'b0;
    if (new_t) begin
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + ONE;
        due    = (fill_q == FILL_LAST);
      end else if (hop_q == HOP_LAST) begin
        hop_d = '0;
        due   = 1'b1;
      end else begin
        hop_d = hop_q + ONE;
      end
    end
  end

  assign launch       = due && enable;
  assign window_ready = (fill_q == FILL_MAX);

`ifdef FFT_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        expire;

  // Counter sits at zero outside BUSY, so it is clear on BUSY entry.
  assign wd_d    = (state_q == S_BUSY) ? wd_q + 16'd1 : 16'd0;
  assign expire  = (state_q == S_BUSY) && !fft_done
                   && (wd_q == WD_LAST);
  assign err_d   = err_q | expire;
  assign fft_err = err_q;
`else
  logic expire;

  assign expire  = 1'b0;
  assign fft_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    drop_inc   = 1'b0;
    snap       = 1'b0;
    fft_start  = 1'b0;
    fft_active = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch) state_d = S_SNAP;
      end
      S_SNAP: begin
        snap     = 1'b1;
        drop_inc = launch;
        state_d  = S_START;
      end
      S_START: begin
        fft_start  = 1'b1;
        fft_active = 1'b1;
        drop_inc   = launch;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        fft_active = 1'b1;
        if (fft_done) begin
          // A frame due on the completion cycle chains straight on.
          frame_d = frame_q + 16'd1;
          state_d = launch ? S_SNAP : S_IDLE;
        end else begin
          drop_inc = launch;
          if (expire) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drop_d = (drop_inc && drop_q != 8'hFF)
                  ? drop_q + 8'd1 : drop_q;

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      hop_q   <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hop_q   <= hop_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FFT_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
